if_fetch_queue: RTL and testbench

- Instruction-fetch stage directly upstream of decode.
- Owns the fetch PC and issues in-order requests to instruction memory, which accepts variable-latency responses.
- Buffers returned instructions with their PCs in a DEPTH-entry queue and presents them to decode via a valid/ready handshake.
- id_inst[31:7] feeds the decode-stage immediate extender directly; branch/jump redirects flush in-flight and queued work.

---
 rtl/if_fetch_queue.sv | 112 +++++++++++
 tb/tb_if_fetch_queue.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order imem requests under a credit limit,
// and buffers {inst, pc} pairs in a DEPTH-entry queue toward decode.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam int          PW  = $clog2(DEPTH);
  localparam int          CW  = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [CW:0] credit_used;
  logic        req_fire;
  logic        resp_push;
  logic        pop;
  logic [31:0] redirect_aligned;
  logic        unused_redirect_lsb;

  assign redirect_aligned    = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_comb begin
    credit_used = {1'b0, inflight_q} + {1'b0, count_q};
    // Queued plus in-flight never exceeds DEPTH, so a response always has a slot.
    imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    imem_addr      = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    resp_push      = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
    id_valid       = (count_q != '0);
    pop            = id_valid && id_ready && !redirect_valid;

    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_resp_valid);
    fetch_pc_d = req_fire ? fetch_pc_q + 32'd4 : fetch_pc_q;
    resp_pc_d  = resp_push ? resp_pc_q + 32'd4 : resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (imem_resp_valid && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - CW'(1);
    count_d  = count_q + CW'(resp_push) - CW'(pop);
    wr_ptr_d = resp_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;

    // Redirect flushes the queue and marks every still-outstanding request as stale.
    if (redirect_valid) begin
      fetch_pc_d = redirect_aligned;
      resp_pc_d  = redirect_aligned;
      drop_cnt_d = inflight_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resp_push) begin
      inst_mem[wr_ptr_q] <= imem_resp_data;
      pc_mem[wr_ptr_q]   <= resp_pc_q;
    end
  end

  // id_inst[31:7] goes straight to the immediate extender, so empty shows a clean NOP.
  always_comb begin
    id_inst     = id_valid ? inst_mem[rd_ptr_q] : NOP;
    id_pc       = id_valid ? pc_mem[rd_ptr_q] : 32'd0;
    id_pc_plus4 = id_valid ? pc_mem[rd_ptr_q] + 32'd4 : 32'd0;
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a fixed-latency in-order imem model.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_ready = 1'b0;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cyc = 0;
  logic rdy_rand = 1'b0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  if_fetch_queue #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .id_valid(id_valid), .id_inst(id_inst),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  // imem model: data word is address ^ 0xDEAD0000, response lat cycles after acceptance.
  always @(posedge clk) begin
    if (rst) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (imem_resp_valid) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (imem_req_valid && imem_req_ready) begin
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + lat);
      end
    end
    cyc = cyc + 1;
    #1;
    imem_req_ready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    imem_resp_valid = !rst && (pend_due.size() > 0) && (pend_due.size() > 0 ? pend_due[0] <= cyc : 1'b0);
    imem_resp_data  = imem_resp_valid ? (pend_addr[0] ^ 32'hDEAD_0000) : 32'd0;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    lat = l;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    rdy_rand = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid got %0b exp 0", imem_req_valid); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %0b exp 0", id_valid); end
    checks++; if (id_inst !== 32'h13) begin errors++; $display("FAIL rst_id_inst got %h exp 00000013", id_inst); end
    checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL rst_id_pc got %h exp 0", id_pc); end
    checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_id_pc_plus4 got %h exp 0", id_pc_plus4); end
  endtask

  task automatic test_stream();
    do_reset(1);
    id_ready = 1'b1;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL stream_c0 got v=%0b a=%h exp v=1 a=00000100", imem_req_valid, imem_addr); end
    step();
    checks++; if (imem_addr !== 32'h104 || id_valid !== 1'b0) begin errors++; $display("FAIL stream_c1 got a=%h idv=%0b exp a=00000104 idv=0", imem_addr, id_valid); end
    step();
    checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL stream_c2_addr got %h exp 00000108", imem_addr); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin errors++; $display("FAIL stream_c2_head got v=%0b pc=%h exp v=1 pc=00000100", id_valid, id_pc); end
    checks++; if (id_pc_plus4 !== 32'h104) begin errors++; $display("FAIL stream_c2_plus4 got %h exp 00000104", id_pc_plus4); end
    checks++; if (id_inst !== 32'hDEAD_0100) begin errors++; $display("FAIL stream_c2_inst got %h exp dead0100", id_inst); end
    step();
    checks++; if (id_pc !== 32'h104 || id_inst !== 32'hDEAD_0104) begin errors++; $display("FAIL stream_c3 got pc=%h inst=%h exp 00000104 dead0104", id_pc, id_inst); end
  endtask

  task automatic test_backpressure();
    int hs;
    logic [31:0] last_addr;
    do_reset(1);
    hs = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid && imem_req_ready) hs++;
      step();
    end
    checks++; if (hs !== 4) begin errors++; $display("FAIL bp_issued got %0d exp 4", hs); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_held got %0b exp 0", imem_req_valid); end
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin errors++; $display("FAIL bp_head got v=%0b pc=%h exp v=1 pc=00000100", id_valid, id_pc); end
    id_ready = 1'b1;
    step();
    id_ready = 1'b0;
    checks++; if (id_pc !== 32'h104) begin errors++; $display("FAIL bp_after_pop got %h exp 00000104", id_pc); end
    hs = 0;
    last_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      if (imem_req_valid && imem_req_ready) begin hs++; last_addr = imem_addr; end
      step();
    end
    checks++; if (hs !== 1) begin errors++; $display("FAIL bp_one_more got %0d exp 1", hs); end
    checks++; if (last_addr !== 32'h110) begin errors++; $display("FAIL bp_one_addr got %h exp 00000110", last_addr); end
  endtask

  task automatic test_redirect_drop();
    int n;
    do_reset(3);
    id_ready = 1'b1;
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2002;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_req_in_redirect got %0b exp 0", imem_req_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rd_queue_empty got %0b exp 0", id_valid); end
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h2000) begin errors++; $display("FAIL rd_new_req got v=%0b a=%h exp v=1 a=00002000", imem_req_valid, imem_addr); end
    n = 0;
    while (!id_valid && n < 20) begin step(); n++; end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL rd_timeout got id_valid=%0b exp 1", id_valid); end
    checks++; if (id_pc !== 32'h2000 || id_inst !== 32'hDEAD_2000) begin errors++; $display("FAIL rd_first got pc=%h inst=%h exp 00002000 dead2000", id_pc, id_inst); end
    checks++; if (id_pc_plus4 !== 32'h2004) begin errors++; $display("FAIL rd_plus4 got %h exp 00002004", id_pc_plus4); end
  endtask

  task automatic test_redirect_same_cycle();
    int n;
    do_reset(2);
    step();
    step();
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    #1;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin errors++; $display("FAIL sc_old_head got v=%0b pc=%h exp v=1 pc=00000100", id_valid, id_pc); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL sc_req_in_redirect got %0b exp 0", imem_req_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL sc_flushed got %0b exp 0", id_valid); end
    step();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL sc_stale_dropped got v=%0b inst=%h exp v=0", id_valid, id_inst); end
    id_ready = 1'b1;
    n = 0;
    while (!id_valid && n < 20) begin step(); n++; end
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL sc_timeout got id_valid=%0b exp 1", id_valid); end
    checks++; if (id_pc !== 32'h3000 || id_inst !== 32'hDEAD_3000) begin errors++; $display("FAIL sc_first got pc=%h inst=%h exp 00003000 dead3000", id_pc, id_inst); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_addr;
    logic [31:0] exp_id;
    logic wrapped;
    do_reset(1);
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    rdy_rand = 1'b1;
    step();
    redirect_valid = 1'b0;
    #1;
    exp_addr = 32'hFFFF_FFF8;
    exp_id = 32'hFFFF_FFF8;
    wrapped = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req_valid) begin
        checks++; if (imem_addr !== exp_addr) begin errors++; $display("FAIL wrap_addr got %h exp %h", imem_addr, exp_addr); end
        if (imem_req_ready) begin
          if (exp_addr == 32'h0) wrapped = 1'b1;
          exp_addr = exp_addr + 32'd4;
        end
      end
      if (id_valid) begin
        checks++; if (id_pc !== exp_id || id_inst !== (exp_id ^ 32'hDEAD_0000)) begin errors++; $display("FAIL wrap_id got pc=%h inst=%h exp pc=%h", id_pc, id_inst, exp_id); end
        exp_id = exp_id + 32'd4;
      end
      step();
    end
    rdy_rand = 1'b0;
    checks++; if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_seen got %0b exp 1", wrapped); end
  endtask

  task automatic test_async_reset();
    do_reset(1);
    step();
    step();
    step();
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL ar_pre got v=%0b pc=%h req=%0b exp 1 00000100 0", id_valid, id_pc, imem_req_valid); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin errors++; $display("FAIL ar_valids got idv=%0b req=%0b exp 0 0", id_valid, imem_req_valid); end
    checks++; if (id_inst !== 32'h13 || id_pc !== 32'h0 || id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL ar_outputs got %h %h %h exp 00000013 0 0", id_inst, id_pc, id_pc_plus4); end
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL ar_first_req got v=%0b a=%h exp v=1 a=00000100", imem_req_valid, imem_addr); end
    id_ready = 1'b1;
    step();
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_inst !== 32'hDEAD_0100) begin errors++; $display("FAIL ar_first_head got v=%0b pc=%h inst=%h exp 1 00000100 dead0100", id_valid, id_pc, id_inst); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
